// File: rtl/range_pkg.sv
// Shared types and constants for the range-finder sequencing controller.
package range_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    ABORT   = 3'd4
  } state_e;

  // Shortest window the datapath can take without go and finish colliding.
  localparam int MIN_WIN   = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/range_result_buf.sv
// One-entry valid/ready holding register for window results, with a sticky
// overrun flag raised when an unaccepted result is replaced.
module range_result_buf
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr_ovr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_range,
  input  logic             i_err,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_range,
  output logic             o_err,
  output logic             o_overrun
);

  logic             r_valid;
  logic [WIDTH-1:0] r_range;
  logic             r_err;
  logic             r_ovr;

  // Load beats acceptance; a load during acceptance is a clean hand-over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_range <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_range <= i_range;
        r_err   <= i_err;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_clr_ovr) begin
        r_ovr <= 1'b0;
      end else if (i_load && r_valid && !i_ready) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_range   = r_range;
  assign o_err     = r_err;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/range_window_ctrl.sv
// Window sequencer between the sample stream and the range-finder datapath.
// Optional idle-sample watchdog: define RANGE_CTRL_TIMEOUT_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | disarmed; arms on enable with a legal win_len
//   ARMED   | waiting for the first sample of a window (rf_go follows)
//   RUN     | collecting samples; a set rf_finish marks the finish cycle
//   CAPTURE | datapath result valid; loaded into the result buffer
//   ABORT   | enable dropped mid-window; one rf_finish, result discarded
module range_window_ctrl
  import range_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             continuous,
  input  logic [CNT_W-1:0] win_len,
  output logic             cfg_err,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_range,
  output logic             res_err,
  output logic             res_overrun
);

  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rf_data;
  logic             r_rf_go;
  logic             r_rf_finish;
  logic             r_cfg_err;
  logic             w_cfg_bad;
  logic             w_hs;
  logic             w_last;
  logic             w_abort;
  logic             w_tmo_fire;
  logic             w_tmo_flag;

  assign w_cfg_bad = (win_len < CNT_W'(MIN_WIN));
  // Gated by enable so nothing is accepted on the cycle a window is aborted;
  // the finish cycle in RUN takes no sample so the datapath can settle.
  assign s_ready   = enable && ((r_state == ARMED) || ((r_state == RUN) && !r_rf_finish));
  assign w_hs      = s_valid && s_ready;
  assign w_last    = (r_state == RUN) && w_hs && ((r_cnt + 1'b1) == r_len);
  assign w_abort   = (r_state == RUN) && !r_rf_finish && !enable;

`ifdef RANGE_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_tmo;

  assign w_tmo_fire = (r_state == RUN) && !r_rf_finish && enable && !w_hs && (r_wd == '0);
  assign w_tmo_flag = r_tmo;

  // Down-counter of idle RUN cycles, reloaded on every accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd  <= WD_LOAD;
      r_tmo <= 1'b0;
    end else begin
      if ((r_state != RUN) || w_hs) begin
        r_wd <= WD_LOAD;
      end else if (r_wd != '0) begin
        r_wd <= r_wd - 1'b1;
      end
      if (w_tmo_fire) begin
        r_tmo <= 1'b1;
      end else if ((r_state == CAPTURE) || (r_state == IDLE)) begin
        r_tmo <= 1'b0;
      end
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign w_tmo_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable && !w_cfg_bad) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable)   w_state_nxt = IDLE;
        else if (w_hs) w_state_nxt = RUN;
      end
      RUN: begin
        // A finish already on the wire is not repeated if enable drops now.
        if (r_rf_finish) w_state_nxt = enable ? CAPTURE : IDLE;
        else if (!enable) w_state_nxt = ABORT;
      end
      CAPTURE: begin
        w_state_nxt = (continuous && enable) ? ARMED : IDLE;
      end
      ABORT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath strobes, sample register, window counter and config latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf_data   <= '0;
      r_rf_go     <= 1'b0;
      r_rf_finish <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
    end else begin
      r_cfg_err   <= (r_state == IDLE) && enable && w_cfg_bad;
      r_rf_go     <= (r_state == ARMED) && w_hs;
      r_rf_finish <= w_last || w_abort || w_tmo_fire;
      if (w_hs) r_rf_data <= s_data;
      if ((r_state == IDLE) && enable && !w_cfg_bad) r_len <= win_len;
      if ((r_state == ARMED) && w_hs) begin
        r_cnt <= CNT_W'(1);
      end else if ((r_state == RUN) && w_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == IDLE) begin
        r_cnt <= '0;
      end
    end
  end

  assign rf_data   = r_rf_data;
  assign rf_go     = r_rf_go;
  assign rf_finish = r_rf_finish;
  assign cfg_err   = r_cfg_err;

  range_result_buf #(
    .WIDTH (WIDTH)
  ) u_res_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr_ovr (!enable),
    .i_load    (r_state == CAPTURE),
    .i_range   (rf_range),
    .i_err     (rf_error || w_tmo_flag),
    .i_ready   (res_ready),
    .o_valid   (res_valid),
    .o_range   (res_range),
    .o_err     (res_err),
    .o_overrun (res_overrun)
  );

endmodule

// File: tb/tb_range_window_ctrl.sv
// Bench for range_window_ctrl: datapath emulator plus a window-level model
// of the result stream, driven by directed scenarios and random phases.
module tb_range_window_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int TMO   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             continuous = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic             cfg_err;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready;
  logic [WIDTH-1:0] rf_data;
  logic             rf_go;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_range = '0;
  logic             rf_error = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_range;
  logic             res_err;
  logic             res_overrun;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  range_window_ctrl #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .continuous  (continuous),
    .win_len     (win_len),
    .cfg_err     (cfg_err),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .rf_data     (rf_data),
    .rf_go       (rf_go),
    .rf_finish   (rf_finish),
    .rf_range    (rf_range),
    .rf_error    (rf_error),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_range   (res_range),
    .res_err     (res_err),
    .res_overrun (res_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Datapath emulator: min/max from rf_go through rf_finish, range = max-min.
  int               dp_min = 0;
  int               dp_max = 0;
  int               go_cnt = 0;
  int               fin_cnt = 0;
  logic [WIDTH-1:0] go_dat = '0;
  logic [WIDTH-1:0] fin_dat = '0;

  always @(negedge clk) begin
    if (rf_go) begin
      dp_min = int'(rf_data);
      dp_max = int'(rf_data);
      go_cnt++;
      go_dat = rf_data;
    end else begin
      if (int'(rf_data) < dp_min) dp_min = int'(rf_data);
      if (int'(rf_data) > dp_max) dp_max = int'(rf_data);
    end
    if (rf_finish) begin
      fin_cnt++;
      fin_dat  = rf_data;
      rf_range = WIDTH'(dp_max - dp_min);
      rf_error = ((dp_max - dp_min) < 8);
    end
  end

  // Window-level model: accepted samples form windows of win_len; a result
  // lands in the buffer at the end of the second cycle after the last sample.
  logic [WIDTH-1:0] q[$];
  int               cd = 0;
  int               m_wins = 0;
  logic             m_valid = 1'b0;
  logic             m_ovr = 1'b0;
  logic             m_err = 1'b0;
  logic [WIDTH-1:0] m_range = '0;
  logic [WIDTH-1:0] p_range = '0;
  logic             p_err = 1'b0;
  logic [WIDTH-1:0] m_last = '0;
  logic             m_en_prev = 1'b0;
  bit               m_chk = 1'b1;

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic rr, output logic hs);
    logic ld;
    int mn, mx;
    s_valid   = v;
    s_data    = d;
    res_ready = rr;
    @(negedge clk);
    hs = s_valid && s_ready;
    check("rf_data_hold", rf_data, m_last);
    if (m_chk) begin
      check("res_valid", res_valid, m_valid);
      check("res_overrun", res_overrun, m_ovr);
      if (m_valid) begin
        check("res_range", res_range, m_range);
        check("res_err", res_err, m_err);
      end
      if (cd != 0 || !m_en_prev) check("s_ready_low", s_ready, 1'b0);
      else if (enable && q.size() != 0) check("s_ready_high", s_ready, 1'b1);
    end
    if (!rst_n) begin
      q.delete();
      cd      = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_range = '0;
      m_err   = 1'b0;
      m_last  = '0;
    end else begin
      if (hs) m_last = d;
      ld = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) ld = 1'b1;
      end
      if (ld) begin
        if (m_valid && !rr) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_range = p_range;
        m_err   = p_err;
      end else if (m_valid && rr) begin
        m_valid = 1'b0;
      end
      if (!enable) begin
        m_ovr = 1'b0;
        q.delete();
      end else if (hs) begin
        q.push_back(d);
        if (q.size() == int'(win_len)) begin
          mn = 255;
          mx = 0;
          foreach (q[i]) begin
            if (int'(q[i]) < mn) mn = int'(q[i]);
            if (int'(q[i]) > mx) mx = int'(q[i]);
          end
          p_range = WIDTH'(mx - mn);
          p_err   = ((mx - mn) < 8);
          q.delete();
          cd = 2;
          m_wins++;
        end
      end
    end
    m_en_prev = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic hs;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rr, hs);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic rr);
    logic hs;
    int n = 0;
    do begin
      cyc(1'b1, d, rr, hs);
      n++;
    end while (!hs && n < 50);
    check("send_accept", hs, 1'b1);
  endtask

  task automatic wait_ready();
    logic hs;
    int n = 0;
    while (!s_ready && n < 20) begin
      cyc(1'b0, '0, 1'b1, hs);
      n++;
    end
    check("arm_ready", s_ready, 1'b1);
  endtask

  task automatic gap();
    enable = 1'b0;
    idle(3, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_rf_data"}, rf_data, '0);
    check({tag, "_rf_go"}, rf_go, 1'b0);
    check({tag, "_rf_finish"}, rf_finish, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_cfg_err"}, cfg_err, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_range"}, res_range, '0);
    check({tag, "_res_err"}, res_err, 1'b0);
    check({tag, "_res_overrun"}, res_overrun, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic hs;
    int g0, f0, w0, n, streak;
    logic [WIDTH-1:0] acc[$];
    logic [WIDTH-1:0] a, b, c, d;
    logic [5:0] pat;

    // Reset.
    rst_n = 1'b0;
    idle(2, 1'b0);
    rst_n = 1'b1;
    chk_all_zero("reset");

    // Single window, non-continuous.
    continuous = 1'b0;
    win_len    = 8'd4;
    enable     = 1'b1;
    g0 = go_cnt;
    f0 = fin_cnt;
    send(8'd10, 1'b0);
    send(8'd200, 1'b0);
    send(8'd3, 1'b0);
    send(8'd50, 1'b0);
    idle(2, 1'b0);
    check("single_go_cnt", go_cnt - g0, 1);
    check("single_fin_cnt", fin_cnt - f0, 1);
    check("single_go_dat", go_dat, 8'd10);
    check("single_fin_dat", fin_dat, 8'd50);
    check("single_valid", res_valid, 1'b1);
    check("single_range", res_range, 8'd197);
    check("single_err", res_err, 1'b0);
    check("single_back_idle", s_ready, 1'b0);
    idle(1, 1'b1);
    gap();

    // Stalled stream.
    win_len = 8'd3;
    enable  = 1'b1;
    wait_ready();
    g0 = go_cnt;
    f0 = fin_cnt;
    acc.delete();
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      d = WIDTH'($urandom);
      cyc(pat[i], d, 1'b1, hs);
      if (hs) acc.push_back(d);
    end
    idle(3, 1'b1);
    check("stall_accepts", acc.size(), 3);
    check("stall_go_cnt", go_cnt - g0, 1);
    check("stall_fin_cnt", fin_cnt - f0, 1);
    if (acc.size() == 3) begin
      check("stall_go_dat", go_dat, acc[0]);
      check("stall_fin_dat", fin_dat, acc[2]);
    end
    gap();

    // Continuous mode with backpressure.
    continuous = 1'b1;
    win_len    = 8'd2;
    enable     = 1'b1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = WIDTH'($urandom);
    d = WIDTH'($urandom);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
    idle(3, 1'b0);
    check("bp_overrun", res_overrun, 1'b1);
    check("bp_range", res_range, (c > d) ? WIDTH'(c - d) : WIDTH'(d - c));
    idle(1, 1'b1);
    check("bp_valid_cleared", res_valid, 1'b0);
    check("bp_overrun_sticky", res_overrun, 1'b1);
    gap();
    check("bp_overrun_cleared", res_overrun, 1'b0);

    // Configuration rejection.
    continuous = 1'b0;
    win_len    = 8'd1;
    enable     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) win_len = 8'd0;
      cyc(1'b1, 8'hA5, 1'b1, hs);
      check("cfg_err_pulse", cfg_err, 1'b1);
      check("cfg_no_ready", s_ready, 1'b0);
    end
    win_len = 8'd2;
    idle(1, 1'b1);
    check("cfg_err_clear", cfg_err, 1'b0);
    wait_ready();
    f0 = fin_cnt;
    gap();
    check("armed_drop_no_finish", fin_cnt - f0, 0);

    // Abort mid-RUN.
    win_len = 8'd4;
    enable  = 1'b1;
    send(WIDTH'($urandom), 1'b1);
    send(WIDTH'($urandom), 1'b1);
    f0 = fin_cnt;
    enable = 1'b0;
    idle(4, 1'b0);
    check("abort_fin_cnt", fin_cnt - f0, 1);
    check("abort_no_result", res_valid, 1'b0);
    check("abort_idle", s_ready, 1'b0);

    // Reset mid-window.
    enable = 1'b1;
    send(WIDTH'($urandom), 1'b1);
    send(WIDTH'($urandom), 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b1, hs);
    rst_n = 1'b1;
    chk_all_zero("midreset");
    g0 = go_cnt;
    acc.delete();
    for (int i = 0; i < 4; i++) begin
      d = WIDTH'($urandom);
      acc.push_back(d);
      send(d, 1'b1);
    end
    idle(3, 1'b1);
    check("midreset_go_cnt", go_cnt - g0, 1);
    check("midreset_go_dat", go_dat, acc[0]);
    check("midreset_fin_dat", fin_dat, acc[3]);
    gap();

    // Random phases against the model.
    for (int ph = 0; ph < 4; ph++) begin
      continuous = 1'($urandom_range(0, 1));
      win_len    = CNT_W'($urandom_range(2, 6));
      enable     = 1'b1;
      w0 = m_wins;
      n = 0;
      streak = 0;
      while ((m_wins - w0 < 4 || cd != 0) && n < 400) begin
        logic v;
        v = ($urandom_range(0, 3) != 0) || (streak >= 3);
        streak = v ? 0 : streak + 1;
        cyc(v, WIDTH'($urandom), 1'($urandom_range(0, 1)), hs);
        n++;
      end
      check("rand_progress", (m_wins - w0 >= 4), 1'b1);
      gap();
    end

`ifdef RANGE_CTRL_TIMEOUT_EN
    // Watchdog: two samples, then the stream goes quiet.
    m_chk      = 1'b0;
    continuous = 1'b0;
    win_len    = 8'd4;
    enable     = 1'b1;
    send(8'd40, 1'b0);
    send(8'd60, 1'b0);
    f0 = fin_cnt;
    n = 0;
    while (fin_cnt == f0 && n < 20) begin
      idle(1, 1'b0);
      n++;
    end
    check("tmo_finish_delay", n, TMO + 1);
    idle(2, 1'b0);
    check("tmo_valid", res_valid, 1'b1);
    check("tmo_err", res_err, 1'b1);
    check("tmo_range", res_range, 8'd20);
    gap();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/range_window_ctrl.md
# range_window_ctrl

Sequencing controller for the range-finder datapath. Accepts a valid/ready sample stream, cuts it into fixed-length windows, and drives the datapath's data/go/finish strobes. Captures each window's range and error flag into a one-entry valid/ready result buffer. Sits between the top-level pin wrapper and the range-finder instance, so the datapath never sees stalls or malformed go/finish sequences.

## Interface
Parameters:
- WIDTH, 8: sample and range width.
- CNT_W, 8: window-length counter width.
- TIMEOUT_CYC, 255: idle-sample watchdog limit. Used only with RANGE_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- enable  in  1  arms the controller. Deassertion aborts any open window.
- continuous  in  1  1: re-arm automatically after each result. 0: return to IDLE after one window.
- win_len  in  CNT_W  samples per window. Latched on the IDLE->ARMED transition.
- cfg_err  out  1  one-cycle pulse when arming is rejected because win_len < 2.
- s_valid  in  1  sample valid.
- s_data  in  WIDTH  sample.
- s_ready  out  1  high in ARMED and RUN only.
- rf_data  out  WIDTH  registered sample to datapath.
- rf_go  out  1  registered; high exactly on the cycle rf_data carries a window's first sample.
- rf_finish  out  1  registered; high exactly on the cycle rf_data carries a window's last sample.
- rf_range  in  WIDTH  datapath range; valid in the cycle after rf_finish.
- rf_error  in  1  datapath error; valid with rf_range.
- res_valid, res_ready  out/in  1  result handshake.
- res_range  out  WIDTH  captured range.
- res_err  out  1  captured rf_error, OR'ed with the timeout flag when the watchdog is compiled in.
- res_overrun  out  1  sticky flag. Set when an unaccepted result is overwritten. Cleared by reset or by enable=0.

## Operation
States: IDLE, ARMED, RUN, CAPTURE, ABORT.
- **IDLE**
  - With enable=1 and win_len>=2: latch win_len and go to ARMED.
  - With enable=1 and win_len<2: pulse cfg_err for one cycle and stay in IDLE. cfg_err re-pulses each cycle while the condition holds.
- **ARMED**
  - A sample handshake (s_valid & s_ready) registers s_data to rf_data with rf_go=1 next cycle.
  - Counter loads 1; go to RUN.
- **RUN**
  - Each handshake registers s_data to rf_data and increments the counter.
  - On the handshake that brings the count to the latched win_len, assert rf_finish with that sample and go to CAPTURE.
  - Cycles without a handshake hold rf_data at the last sample with rf_go=rf_finish=0. Repeating a sample leaves min/max unchanged.
- **CAPTURE**
  - One cycle with s_ready=0.
  - At its closing edge: rf_range→res_range, rf_error→res_err, res_valid=1.
  - Next state is ARMED if continuous & enable, else IDLE.
- **ABORT**
  - Entered when enable drops in RUN. Drives rf_finish=1 for one cycle with rf_data held.
  - The datapath result is discarded; go to IDLE.
  - enable drop in ARMED goes straight to IDLE with no strobes.
- **Result buffer**
  - res_valid clears on res_valid & res_ready.
  - A capture while res_valid=1 and res_ready=0 overwrites the buffer and sets res_overrun.
  - A capture in the same cycle as acceptance is not an overrun: the old result leaves and the new one loads.
- Counter is CNT_W bits and never wraps, because win_len is at most 2^CNT_W−1.

## Timing
- Reset values (one edge with rst_n=0, from any state):
  - all outputs 0, except rf_data=0;
  - state IDLE, counter 0, buffer empty, overrun cleared.
- Sample handshake in cycle k: rf_data valid in cycle k+1.
  - If it is the last sample: rf_finish in k+1, CAPTURE in k+2, res_valid from k+3.
  - In continuous mode, s_ready is high again in k+3.
- Window throughput: win_len + 2 cycles minimum.
- rf_go and rf_finish are never high in the same cycle, because win_len>=2.

## Configuration
- RANGE_CTRL_TIMEOUT_EN defined:
  - In RUN, a counter tracks consecutive cycles without a handshake.
  - Reaching TIMEOUT_CYC forces rf_finish with rf_data held, then CAPTURE.
  - The captured res_err is forced to 1.
- Undefined: no watchdog; RUN waits indefinitely.

## Structure
- Package range_pkg holds:
  - the state enum type (IDLE, ARMED, RUN, CAPTURE, ABORT);
  - constant MIN_WIN=2;
  - default WIDTH and CNT_W values, shared with the datapath and the top level.
- One sub-module: range_result_buf, the one-entry valid/ready holding register with overrun detection.
- The FSM, window counter and watchdog live in range_window_ctrl.

## Test plan
- **Single window:** win_len=4, continuous=0, samples 10,200,3,50 back-to-back, rf_range model=max−min.
  - rf_go with 10; rf_finish with 50.
  - res_range=197 with res_err=0, res_valid 3 cycles after the last handshake.
  - Controller returns to IDLE.
- **Stalled stream:** win_len=3, s_valid toggling 1,0,0,1,0,1.
  - rf_data holds between handshakes.
  - Exactly one rf_go and one rf_finish, with rf_finish on the third accepted sample.
- **Continuous mode with backpressure:** continuous=1, win_len=2, res_ready=0 across two windows.
  - Second result overwrites the first; res_overrun=1.
  - Asserting res_ready for one cycle clears res_valid; res_overrun stays 1.
- **Configuration and abort:**
  - win_len=1 with enable=1 → cfg_err pulses and s_ready stays 0.
  - enable dropped mid-RUN → one rf_finish cycle, res_valid stays 0, state returns to IDLE.
- **Reset mid-window:** rst_n=0 for one edge during RUN → every output 0 the following cycle; the next window starts cleanly with rf_go.
- **Timeout (macro defined, TIMEOUT_CYC=5):** s_valid stuck at 0 after two samples → rf_finish after 5 idle cycles, res_err=1.
